// File: rtl/prod_accum.sv
// -----------------------------------------------------------------------------
// prod_accum
//   Frame accumulator for the multiplier's registered product stream. Sums N
//   consecutive unsigned products into one frame result. The sum saturates at
//   2^AW-1 and carries a sticky overflow flag. The result is handed to the
//   next stage over a valid/ready handshake.
//
//   Products are accepted only while accumulating (ACC). The result is offered
//   only while holding (HOLD). Because of this, in_ready and out_valid are never
//   high together, and both depend only on the state register.
//
// Parameters
//   PW  product width (bits)
//   N   products per frame (2..256)
//   AW  accumulator / result width (bits)
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous, active-high reset
//   in_valid   upstream product valid
//   in_ready   block can accept a product this cycle (state ACC)
//   in_data    unsigned product, PW bits
//   out_valid  frame result valid (state HOLD)
//   out_ready  downstream accepts the result
//   out_sum    saturated frame sum, AW bits
//   out_ovf    frame sum exceeded 2^AW-1 at some point in the frame
//   frame_cnt  number of frames handed off, wraps 255 -> 0
// -----------------------------------------------------------------------------
module prod_accum #(
  parameter int PW = 8,
  parameter int N  = 4,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf,
  output logic [7:0]    frame_cnt
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        state_q,     state_d;
  logic [AW-1:0] acc_q,       acc_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          ovf_q,       ovf_d;
  logic [AW-1:0] out_sum_q,   out_sum_d;
  logic          out_ovf_q,   out_ovf_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic [AW:0]   add_s;
  logic          carry_s;
  logic [AW-1:0] sat_s;

  // Clamp an (AW+1)-bit sum to AW bits, using the top bit as the carry.
  function automatic logic [AW-1:0] sat_fn(input logic [AW:0] x);
    sat_fn = x[AW] ? {AW{1'b1}} : x[AW-1:0];
  endfunction

  // Add one bit of headroom so the carry is visible. Once acc is all-ones,
  // any non-zero product sets the carry again. So acc stays saturated and the
  // overflow flag stays set for the rest of the frame.
  assign add_s   = (AW+1)'(acc_q) + (AW+1)'(in_data);
  assign carry_s = add_s[AW];
  assign sat_s   = sat_fn(add_s);

  // Handshake outputs decode the state register only.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign frame_cnt = frame_cnt_q;

  // Next-state and datapath update for the ACC/HOLD machine.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          if (cnt_q == LAST) begin
            // Last product of the frame: publish the result and clear for the next frame.
            out_sum_d = sat_s;
            out_ovf_d = ovf_q | carry_s;
            acc_d     = {AW{1'b0}};
            cnt_d     = {CW{1'b0}};
            ovf_d     = 1'b0;
            state_d   = ST_HOLD;
          end else begin
            acc_d = sat_s;
            cnt_d = cnt_q + CW'(1);
            ovf_d = ovf_q | carry_s;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_HOLD: begin
        // Result is released here; input acceptance resumes on the next cycle.
        if (out_ready) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = ST_ACC;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State and datapath registers; an async reset drops any partial frame or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= {AW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      ovf_q       <= 1'b0;
      out_sum_q   <= {AW{1'b0}};
      out_ovf_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
module tb_prod_accum;

  logic       clk;
  logic       rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [7:0] a_in_data, a_frame_cnt;
  logic [9:0] a_out_sum;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [7:0] b_in_data, b_frame_cnt;
  logic [8:0] b_out_sum;

  int total;
  int bad;
  int exp_fc_a;
  int exp_fc_b;

  prod_accum #(.PW(8), .N(4), .AW(10)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf), .frame_cnt(a_frame_cnt)
  );

  prod_accum #(.PW(8), .N(4), .AW(9)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .frame_cnt(b_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;   // 0: AW=10 instance, 1: AW=9 instance
    logic [7:0] d [4];
    int         sum;
    bit         ovf;
    string      name;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (a_in_ready && a_out_valid) begin
        bad++;
        $display("FAIL excl_a: in_ready=1 out_valid=1 expected not both");
      end
    end
  end

  task automatic set_vec(input int i, input bit sel, input int d0, input int d1,
                         input int d2, input int d3, input int sum, input bit ovf,
                         input string name);
    tbl[i].sel  = sel;
    tbl[i].d[0] = d0[7:0];
    tbl[i].d[1] = d1[7:0];
    tbl[i].d[2] = d2[7:0];
    tbl[i].d[3] = d3[7:0];
    tbl[i].sum  = sum;
    tbl[i].ovf  = ovf;
    tbl[i].name = name;
  endtask

  // Send one product. Wait (bounded) for in_ready, then hold valid for one edge.
  task automatic put(input bit sel, input logic [7:0] d);
    int k;
    k = 0;
    while (!(sel ? b_in_ready : a_in_ready) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    if (sel) begin b_in_valid = 1'b1; b_in_data = d; end
    else     begin a_in_valid = 1'b1; a_in_data = d; end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  // Call right after the last product edge. Check the held result, release it,
  // then check the handoff.
  task automatic take(input bit sel, input string name, input int exp_sum, input bit exp_ovf);
    logic old_rdy;
    chk({name, "_ovalid"}, sel ? int'(b_out_valid) : int'(a_out_valid), 1);
    chk({name, "_iready_hold"}, sel ? int'(b_in_ready) : int'(a_in_ready), 0);
    chk({name, "_sum"}, sel ? int'(b_out_sum) : int'(a_out_sum), exp_sum);
    chk({name, "_ovf"}, sel ? int'(b_out_ovf) : int'(a_out_ovf), int'(exp_ovf));
    old_rdy = sel ? b_out_ready : a_out_ready;
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk); #1;
    if (sel) begin
      b_out_ready = old_rdy;
      exp_fc_b = (exp_fc_b + 1) % 256;
      chk({name, "_ovalid_off"}, int'(b_out_valid), 0);
      chk({name, "_iready_back"}, int'(b_in_ready), 1);
      chk({name, "_fcnt"}, int'(b_frame_cnt), exp_fc_b);
    end else begin
      a_out_ready = old_rdy;
      exp_fc_a = (exp_fc_a + 1) % 256;
      chk({name, "_ovalid_off"}, int'(a_out_valid), 0);
      chk({name, "_iready_back"}, int'(a_in_ready), 1);
      chk({name, "_fcnt"}, int'(a_frame_cnt), exp_fc_a);
    end
  endtask

  initial begin
    int          ref_sum;
    bit          ref_ovf;
    int          mx;
    logic [7:0]  r [4];
    int          s0;

    total = 0; bad = 0; exp_fc_a = 0; exp_fc_b = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'd0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'd0; b_out_ready = 1'b0;

    set_vec(0, 1'b0, 225, 225, 225, 225, 900,  1'b0, "t1_225x4");
    set_vec(1, 1'b0,   0,   0,   0,   0,   0,  1'b0, "a_zeros");
    set_vec(2, 1'b0, 255, 255, 255, 255, 1020, 1'b0, "a_max");
    set_vec(3, 1'b1, 255, 255, 255,   1, 511,  1'b1, "t4_sat");
    set_vec(4, 1'b1,   1,   1,   1,   1,   4,  1'b0, "t4_after");
    set_vec(5, 1'b1, 128, 128, 128, 127, 511,  1'b0, "b_exact_max");
    set_vec(6, 1'b1, 255, 255,   1,   1, 511,  1'b1, "b_last_ovf");
    set_vec(7, 1'b1,   0,   0,   0,   0,   0,  1'b0, "b_zeros");

    repeat (2) @(posedge clk);
    #1;
    chk("rst_iready", int'(a_in_ready), 1);
    chk("rst_ovalid", int'(a_out_valid), 0);
    chk("rst_sum", int'(a_out_sum), 0);
    chk("rst_ovf", int'(a_out_ovf), 0);
    chk("rst_fcnt", int'(a_frame_cnt), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames, back-to-back, out_ready held high.
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) put(tbl[i].sel, tbl[i].d[j]);
      take(tbl[i].sel, tbl[i].name, tbl[i].sum, tbl[i].ovf);
    end
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;

    // Gapped input: valid every other cycle, in_ready stays high.
    for (int j = 1; j <= 4; j++) begin
      put(1'b0, j[7:0]);
      if (j < 4) begin
        chk("t2_iready_gap", int'(a_in_ready), 1);
        @(posedge clk); #1;
        chk("t2_iready_gap2", int'(a_in_ready), 1);
      end
    end
    take(1'b0, "t2_gapped", 10, 1'b0);

    // Backpressure: result held for 5 cycles; input offered in HOLD must be ignored.
    put(1'b0, 8'd10); put(1'b0, 8'd20); put(1'b0, 8'd30); put(1'b0, 8'd40);
    for (int c = 0; c < 5; c++) begin
      a_in_valid = (c < 2);
      a_in_data  = 8'd77;
      chk("t3_ovalid_held", int'(a_out_valid), 1);
      chk("t3_iready_low", int'(a_in_ready), 0);
      chk("t3_sum_stable", int'(a_out_sum), 100);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    take(1'b0, "t3_release", 100, 1'b0);
    for (int j = 0; j < 4; j++) put(1'b0, 8'd1);
    take(1'b0, "t3_next", 4, 1'b0);

    // Reset mid-frame: partial sum discarded, outputs back to reset values at once.
    put(1'b0, 8'd50);
    put(1'b0, 8'd60);
    rst = 1'b1;
    #1;
    chk("t5_iready", int'(a_in_ready), 1);
    chk("t5_ovalid", int'(a_out_valid), 0);
    chk("t5_sum", int'(a_out_sum), 0);
    chk("t5_ovf", int'(a_out_ovf), 0);
    chk("t5_fcnt", int'(a_frame_cnt), 0);
    chk("t5_fcnt_b", int'(b_frame_cnt), 0);
    #1;
    rst = 1'b0;
    exp_fc_a = 0;
    exp_fc_b = 0;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) put(1'b0, 8'd5);
    take(1'b0, "t5_after", 20, 1'b0);

    // 256 random frames against a saturating reference; frame_cnt wraps through 0.
    a_out_ready = 1'b1;
    mx = 1023;
    for (int f = 0; f < 256; f++) begin
      ref_sum = 0;
      ref_ovf = 1'b0;
      for (int j = 0; j < 4; j++) begin
        r[j] = 8'($urandom_range(0, 255));
        ref_sum = ref_sum + int'(r[j]);
        if (ref_sum > mx) begin
          ref_sum = mx;
          ref_ovf = 1'b1;
        end
      end
      for (int j = 0; j < 4; j++) put(1'b0, r[j]);
      take(1'b0, "t6_frame", ref_sum, ref_ovf);
    end
    s0 = exp_fc_a;
    chk("t6_wrapped", int'(a_frame_cnt), s0);
    a_out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
